clock_div_bank: RTL and testbench
=================================

CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels.
REQ-002 Parameter CNT_W, default 27: width of each half-period counter and register.
REQ-003 Parameter DEF_HALF, default 4_999_999: reset half-period value for all channels (10 Hz from 100 MHz).
REQ-004 CLK  input  1: system clock; all logic on its rising edge.
REQ-005 RST_N  input  1: reset, synchronous and active-low.
REQ-006 EN  input  NUM_CH: per-channel run enable.
REQ-007 WR_EN  input  1: single-cycle write strobe for a half-period value.
REQ-008 WR_CH  input  clog2(NUM_CH): channel index written when WR_EN=1.
REQ-009 WR_HALF  input  CNT_W: new half-period value N; the channel toggles every N+1 CLK cycles.
REQ-010 SYNC  input  1: phase-realign strobe for all channels.
REQ-011 SLOWCLK  output  NUM_CH: per-channel divided square wave, registered.
REQ-012 TICK  output  NUM_CH: per-channel one-cycle pulse, asserted in the cycle SLOWCLK toggles.

Function
REQ-013 Each channel SHALL hold an active half-period register (ACT), a pending register (PEND), a counter (CNT) and SLOWCLK.
REQ-014 With EN[i]=1, CNT[i] SHALL increment each cycle; at CNT[i]==ACT[i] ("terminal"), CNT[i] wraps to 0, SLOWCLK[i] inverts, TICK[i]=1 for that cycle.
REQ-015 With EN[i]=0, CNT[i] and SLOWCLK[i] SHALL hold and TICK[i]=0; counting resumes from the held CNT value on re-enable.
REQ-016 ACT=0 SHALL give a toggle every cycle (CLK/2); ACT=2^CNT_W-1 SHALL be legal, with no overflow past terminal.
REQ-017 A write SHALL load PEND[WR_CH] only; WR_CH >= NUM_CH SHALL be ignored.
REQ-018 PEND SHALL be copied into ACT only at terminal, so a period in progress is never shortened or glitched.
REQ-019 A write coinciding with terminal on the same channel SHALL bypass: ACT takes WR_HALF directly in that cycle.
REQ-020 A channel whose CNT already exceeds a newly loaded ACT cannot occur, because ACT changes only at wrap (REQ-018).
REQ-021 SYNC=1 SHALL force, next cycle, every CNT to 0, every SLOWCLK to 0 and ACT<=PEND, with TICK=0, regardless of EN.
REQ-022 SYNC SHALL override terminal behaviour in the same cycle; a simultaneous write SHALL still land, and ACT SHALL take the written value.
REQ-023 Outputs SHALL be registered; the first toggle after reset or SYNC occurs ACT+1 cycles later.

Reset
REQ-024 While RST_N=0 at a rising CLK edge: CNT=0, SLOWCLK=0, TICK=0, ACT=PEND=DEF_HALF for all channels.
REQ-025 Reset SHALL take priority over SYNC, WR_EN and EN, including when asserted mid-period.

Configuration
REQ-026 With macro CLKDIV_TICK_EN defined, TICK SHALL behave per REQ-014/015/021.
REQ-027 Without CLKDIV_TICK_EN, TICK SHALL be constant 0 and no TICK flops SHALL be synthesised; SLOWCLK SHALL be unchanged.

Structure
REQ-028 Package clkdiv_pkg SHALL hold CNT_W default, NUM_CH default and named half-period constants HALF_10HZ=4_999_999 and HALF_6HZ=8_333_332 (100 MHz base).
REQ-029 Sub-module clock_div_ch SHALL implement one channel (CNT, ACT, PEND, SLOWCLK, TICK); the top SHALL generate NUM_CH instances plus the write decode.

Verification
REQ-030 Reset with DEF_HALF=3, EN=all 1 -> SLOWCLK[0] first rises 4 cycles after RST_N rises and then toggles every 4 cycles; TICK pulses once per toggle.
REQ-031 Write WR_CH=1, WR_HALF=1 mid-period with ACT=3 -> current half-period completes at 4 cycles, then toggles every 2 cycles.
REQ-032 Write WR_CH=2, WR_HALF=0 in the terminal cycle -> the next half-period is exactly 1 cycle (bypass).
REQ-033 Drop EN[0] for 5 cycles at CNT=2 -> SLOWCLK[0] and CNT hold; on re-enable, the toggle occurs 2 cycles later (ACT=3).
REQ-034 Channels at ACT 3 and 5 with SYNC pulsed -> all SLOWCLK=0 and CNT=0 next cycle; outputs realign and rise together at LCM points; SYNC with RST_N=0 -> reset values.
REQ-035 WR_CH=NUM_CH -> no channel changes; with CLKDIV_TICK_EN undefined, TICK is 0 in all of the above.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg - shared constants for the clock divider bank.
//   CNT_W_DEF / NUM_CH_DEF : default counter width and channel count
//   HALF_10HZ / HALF_6HZ   : half-period values for a 100 MHz base clock
//   ch_idx_w()             : width of a channel index (at least 1 bit)
package clkdiv_pkg;

  localparam int CNT_W_DEF  = 27;
  localparam int NUM_CH_DEF = 4;

  // The divider toggles every N+1 cycles, so 10 Hz from 100 MHz needs
  // N = 100e6 / (2*10) - 1.
  localparam int HALF_10HZ = 4_999_999;
  localparam int HALF_6HZ  = 8_333_332;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// clock_div_ch - one divider channel.
//   clk_i      : system clock, rising edge
//   rst_ni     : synchronous active-low reset
//   en_i       : run enable; counter and output hold while low
//   wr_i       : load wr_half_i into the pending half-period
//   wr_half_i  : new half-period N (toggle every N+1 cycles)
//   sync_i     : restart phase: counter and output cleared, pending adopted
//   slowclk_o  : divided square wave (registered)
//   tick_o     : one-cycle pulse on every slowclk_o toggle
// Optional build macro CLKDIV_TICK_EN: when undefined tick_o is tied to 0
// and no tick flop exists.
module clock_div_ch
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(HALF_10HZ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_half_i,
  input  logic             sync_i,
  output logic             slowclk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             slow_q, slow_d;
  logic             term;

  // Terminal only counts when actually running; sync overrides it.
  assign term = en_i && !sync_i && (cnt_q == act_q);

  always_comb begin
    // A write always lands in pending; pend_d is also what act adopts, so a
    // write in the same cycle as a wrap or sync takes effect immediately.
    pend_d = wr_i ? wr_half_i : pend_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    slow_d = slow_q;
    if (sync_i) begin
      cnt_d  = '0;
      slow_d = 1'b0;
      act_d  = pend_d;
    end else if (en_i) begin
      if (term) begin
        // Wrap before the increment can overflow, so an all-ones half-period
        // is legal.
        cnt_d  = '0;
        slow_d = ~slow_q;
        act_d  = pend_d;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      act_q  <= DEF_HALF;
      pend_q <= DEF_HALF;
      slow_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      slow_q <= slow_d;
    end
  end

  assign slowclk_o = slow_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) tick_q <= 1'b0;
    else         tick_q <= term;
  end

  assign tick_o = tick_q;
`else
  assign tick_o = 1'b0;
`endif

endmodule

// File: rtl/clock_div_bank.sv
// clock_div_bank - bank of NUM_CH independent programmable clock dividers.
//   clk_i      : system clock, rising edge
//   rst_ni     : synchronous active-low reset
//   en_i       : per-channel run enable
//   wr_en_i    : single-cycle half-period write strobe
//   wr_ch_i    : channel written; out-of-range indices are ignored
//   wr_half_i  : half-period N; channel toggles every N+1 cycles
//   sync_i     : realign all channels to phase zero
//   slowclk_o  : per-channel divided clock (registered)
//   tick_o     : per-channel toggle pulse
// Optional build macro CLKDIV_TICK_EN enables tick_o (otherwise constant 0).
module clock_div_bank
  import clkdiv_pkg::*;
#(
  parameter int               NUM_CH   = NUM_CH_DEF,
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(HALF_10HZ),
  localparam int              CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_half_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] slowclk_o,
  output logic [NUM_CH-1:0] tick_o
);

  logic [NUM_CH-1:0] wr_sel;

  // One-hot write decode; an index with no matching channel selects nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_en_i && (wr_ch_i == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i[g]),
      .wr_i      (wr_sel[g]),
      .wr_half_i (wr_half_i),
      .sync_i    (sync_i),
      .slowclk_o (slowclk_o[g]),
      .tick_o    (tick_o[g])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// tb_clock_div_bank - self-checking bench for clock_div_bank.
// Small configuration (3 channels, 4-bit counters, reset half-period 3) so the
// all-ones half-period and the out-of-range write index are both reachable.
module tb_clock_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 4;
  localparam int DEF = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [CW-1:0]  wr_half;
  logic           sync;
  logic [NCH-1:0] slow;
  logic [NCH-1:0] tick;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel tracks the number of enabled cycles left
  // until its next toggle and the half-period waiting to be adopted.
  int             m_left [NCH];
  int             m_pend [NCH];
  logic [NCH-1:0] m_slow;
  logic [NCH-1:0] m_tick;

  clock_div_bank #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DEF_HALF (CW'(DEF))
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .wr_en_i   (wr_en),
    .wr_ch_i   (wr_ch),
    .wr_half_i (wr_half),
    .sync_i    (sync),
    .slowclk_o (slow),
    .tick_o    (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] tk(input logic [NCH-1:0] t);
`ifdef CLKDIV_TICK_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_left[c] = DEF + 1;
      m_pend[c] = DEF;
    end
    m_slow = '0;
    m_tick = '0;
  endtask

  task automatic model_step();
    int np;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        np = (wr_en && int'(wr_ch) == c) ? int'(wr_half) : m_pend[c];
        m_tick[c] = 1'b0;
        if (sync) begin
          m_left[c] = np + 1;
          m_slow[c] = 1'b0;
        end else if (en[c]) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            m_slow[c] = ~m_slow[c];
            m_tick[c] = 1'b1;
            m_left[c] = np + 1;
          end
        end
        m_pend[c] = np;
      end
    end
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("slowclk", 32'(slow), 32'(m_slow));
    check("tick", 32'(tick), 32'(tk(m_tick)));
  endtask

  // Run until slowclk[ch] changes; returns the number of edges taken.
  task automatic wait_toggle(input int ch, input int max, output int n);
    logic s0;
    s0 = slow[ch];
    n = 0;
    do begin
      cyc();
      n++;
    end while (slow[ch] === s0 && n < max);
  endtask

  typedef struct {
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           exp_s0;
    logic           exp_t0;
  } vec_t;

  vec_t tbl [10];
  int   n;
  logic s;

  initial begin
    rst_n = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_half = '0; sync = 1'b0;
    model_reset();

    // Reset release with half-period 3: rises on the 4th edge, falls on the 8th.
    tbl[0] = '{1'b0, 3'b111, 1'b0, 1'b0};
    for (int k = 1; k < 10; k++)
      tbl[k] = '{1'b1, 3'b111, (k >= 4 && k < 8), (k == 4 || k == 8)};

    cyc();
    for (int k = 0; k < 10; k++) begin
      rst_n = tbl[k].rst_n;
      en    = tbl[k].en;
      cyc();
      check("tbl_slow0", 32'(slow[0]), 32'(tbl[k].exp_s0));
      check("tbl_tick0", 32'(tick[0]), 32'(tk({2'b00, tbl[k].exp_t0})));
    end

    // Mid-period write: current half-period finishes, then 2-cycle halves.
    sync = 1'b1; cyc(); sync = 1'b0;
    check("sync_clear", 32'(slow), 32'(0));
    cyc();
    wr_en = 1'b1; wr_ch = 2'd1; wr_half = 4'd1; cyc(); wr_en = 1'b0;
    wait_toggle(1, 20, n); check("midwr_first", n, 2);
    wait_toggle(1, 20, n); check("midwr_next", n, 2);
    wait_toggle(1, 20, n); check("midwr_next2", n, 2);

    // Write landing exactly on the terminal cycle bypasses pending.
    sync = 1'b1; cyc(); sync = 1'b0;
    repeat (3) cyc();
    wr_en = 1'b1; wr_ch = 2'd2; wr_half = 4'd0; cyc(); wr_en = 1'b0;
    check("bypass_toggle", 32'(slow[2]), 32'(1));
    wait_toggle(2, 20, n); check("bypass_half", n, 1);
    wait_toggle(2, 20, n); check("bypass_half2", n, 1);

    // Enable drop at count 2 holds everything; 2 cycles remain on re-enable.
    sync = 1'b1; cyc(); sync = 1'b0;
    repeat (2) cyc();
    s = slow[0];
    en = 3'b110;
    repeat (5) cyc();
    check("en_hold", 32'(slow[0]), 32'(s));
    en = 3'b111;
    wait_toggle(0, 20, n); check("en_resume", n, 2);

    // Sync with a simultaneous write: halves 3 and 5 realign at 24 cycles.
    wr_en = 1'b1; wr_ch = 2'd1; wr_half = 4'd5; sync = 1'b1; cyc();
    wr_en = 1'b0; sync = 1'b0;
    check("sync_zero", 32'(slow), 32'(0));
    repeat (24) cyc();
    check("lcm_slow", 32'(slow[1:0]), 32'(0));
    check("lcm_tick", 32'(tick[1:0]), 32'(tk(3'b011) & 3'b011));

    // Reset beats sync; defaults return.
    rst_n = 1'b0; sync = 1'b1; cyc();
    check("rst_over_sync", 32'(slow), 32'(0));
    rst_n = 1'b1; sync = 1'b0;
    wait_toggle(1, 20, n); check("rst_def_half", n, 4);

    // Out-of-range channel index changes nothing.
    wr_en = 1'b1; wr_ch = 2'd3; wr_half = 4'd9; cyc(); wr_en = 1'b0;
    sync = 1'b1; cyc(); sync = 1'b0;
    wait_toggle(0, 20, n); check("badch_ch0", n, 4);

    // All-ones half-period: 16 cycles per half, no overflow.
    wr_en = 1'b1; wr_ch = 2'd0; wr_half = 4'd15; sync = 1'b1; cyc();
    wr_en = 1'b0; sync = 1'b0;
    wait_toggle(0, 40, n); check("max_half", n, 16);
    wait_toggle(0, 40, n); check("max_half2", n, 16);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom % 120) != 0;
      sync    = ($urandom % 40) == 0;
      en      = ($urandom % 4 == 0) ? NCH'($urandom) : '1;
      wr_en   = ($urandom % 6) == 0;
      wr_ch   = 2'($urandom % 4);
      wr_half = ($urandom % 10 == 0) ? 4'd15 : 4'($urandom % 6);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
